// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   data requester. An IDLE/BUSY/RESP FSM grants one access at a time and
//   holds the memory request stable until mem_ready or a wait timeout. It
//   then returns a single-cycle ack, with read data and an error flag, to
//   the requester that owned the access. All outputs are registered.
//
//   Build option: define ARB_ROUND_ROBIN_EN to alternate grants between the
//   two ports on simultaneous requests. Without it the data port always wins.
//
// Parameters
//   TIMEOUT    wait cycles tolerated before an access is abandoned (1..255)
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous reset, active low
//   if_req     fetch request (level)
//   if_addr    fetch address
//   if_rdata   fetch data, valid with if_ack
//   if_ack     fetch completion pulse
//   d_req      data request (level)
//   d_we       data write enable (1 = write)
//   d_addr     data address
//   d_wdata    data write data
//   d_rdata    data read data, valid with d_ack (0 for writes)
//   d_ack      data completion pulse
//   err        timeout flag, high with the ack of an abandoned access
//   mem_req    memory request
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid with mem_ready
//   mem_ready  memory completes the current access this cycle

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        gnt_data_q, gnt_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;

  logic        any_req;
  logic        pick_data;
  logic        timed_out;

  assign any_req   = if_req | d_req;
  // The counter has already counted TIMEOUT waits; a ready in this same
  // cycle still completes the access normally.
  assign timed_out = !mem_ready && (wait_q == TO_CNT);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = the data port received the most recent grant
  logic last_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_data_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      last_data_q <= pick_data;
    end
  end

  assign pick_data = d_req && (!if_req || !last_data_q);
`else
  assign pick_data = d_req;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= 8'd0;
      gnt_data_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      gnt_data_q  <= gnt_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (mem_ready || timed_out) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; acks, read data and err default to 0 so they are
  // only non-zero during the single RESP cycle.
  always_comb begin
    wait_d      = wait_q;
    gnt_data_d  = gnt_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = 32'd0;
    d_rdata_d   = 32'd0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        wait_d = 8'd0;
        if (any_req) begin
          gnt_data_d  = pick_data;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_data & d_we;
          mem_addr_d  = pick_data ? d_addr : if_addr;
          mem_wdata_d = pick_data ? d_wdata : 32'd0;
        end
      end
      BUSY: begin
        if (mem_ready || timed_out) begin
          wait_d      = 8'd0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          err_d       = timed_out;
          if (gnt_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : 32'd0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : 32'd0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        wait_d = 8'd0;
      end
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a memory model with programmable wait
// count, a scoreboard of expected accesses in grant order, and an ack
// monitor that pops and compares completions.

module tb_mem_port_arbiter;

  localparam int TO    = 4;
  localparam int NEVER = 1000;
  localparam int BOUND = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  txn_t sb[$];
  int checks = 0;
  int failures = 0;
  int mem_waits = 0;
  int busy_cnt = 0;
  int last_req_len = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h1234ABCD : (a ^ 32'h5A5AC3C3);
  endfunction

  function automatic txn_t mk(input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit e);
    txn_t t;
    t.is_d  = is_d;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.err   = e;
    t.rdata = (e || we) ? 32'd0 : mem_val(addr);
    return t;
  endfunction

  // Memory model: ready after mem_waits wait cycles, checks request fields
  // against the scoreboard head and their stability while mem_req is high.
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  always @(negedge clk) begin
    if (!mem_req) begin
      if (busy_cnt != 0) last_req_len = busy_cnt;
      busy_cnt  = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
    end else begin
      if (busy_cnt == 0) begin
        if (sb.size() == 0) begin
          chk("mem_unexpected", 64'd1, 64'd0);
        end else begin
          chk("mem_we", {63'd0, mem_we}, {63'd0, sb[0].we});
          chk("mem_addr", {32'd0, mem_addr}, {32'd0, sb[0].addr});
          if (sb[0].we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, sb[0].wdata});
        end
        s_we    = mem_we;
        s_addr  = mem_addr;
        s_wdata = mem_wdata;
      end else begin
        chk("mem_stable", {mem_we, mem_addr, mem_wdata[30:0]}, {s_we, s_addr, s_wdata[30:0]});
      end
      mem_ready = (busy_cnt == mem_waits);
      mem_rdata = mem_ready ? mem_val(mem_addr) : ~mem_val(mem_addr);
      busy_cnt++;
    end
  end

  // Ack monitor
  always @(negedge clk) begin
    txn_t t;
    if (if_ack || d_ack) begin
      chk("ack_onehot", {63'd0, if_ack & d_ack}, 64'd0);
      if (sb.size() == 0) begin
        chk("ack_unexpected", 64'd1, 64'd0);
      end else begin
        t = sb.pop_front();
        chk("ack_port", {63'd0, d_ack}, {63'd0, t.is_d});
        chk("ack_rdata", {32'd0, d_ack ? d_rdata : if_rdata}, {32'd0, t.rdata});
        chk("ack_err", {63'd0, err}, {63'd0, t.err});
        chk("other_rdata", {32'd0, d_ack ? if_rdata : d_rdata}, 64'd0);
      end
    end else begin
      chk("noack_zero", {31'd0, err, if_rdata | d_rdata}, 64'd0);
    end
  end

  task automatic run(input int nd, input int nf, input int waits, input string tag);
    int dn = 0;
    int fn = 0;
    int cyc = 0;
    mem_waits = waits;
    if (nd > 0) d_req = 1'b1;
    if (nf > 0) if_req = 1'b1;
    while ((dn < nd || fn < nf) && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (d_ack) begin
        dn++;
        if (dn >= nd) d_req = 1'b0;
      end
      if (if_ack) begin
        fn++;
        if (fn >= nf) if_req = 1'b0;
      end
    end
    chk({tag, "_done"}, {63'd0, cyc < BOUND}, 64'd1);
    d_req  = 1'b0;
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {59'd0, mem_req, mem_we, if_ack, d_ack, err}, 64'd0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    chk({tag, "_rd"}, {if_rdata, d_rdata}, 64'd0);
  endtask

  initial begin
    // Reset held with a fetch request pending; it is first seen after release
    rst     = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h100;
    sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'd0, 1'b0));
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("reset");
    end
    rst       = 1'b1;
    mem_waits = 0;
    @(negedge clk);
    chk("lat_memreq", {63'd0, mem_req}, 64'd1);
    chk("lat_noack", {62'd0, if_ack, d_ack}, 64'd0);
    @(negedge clk);
    chk("lat_ack", {62'd0, if_ack, mem_req}, 64'd2);
    if_req = 1'b0;
    @(negedge clk);
    chk("lat_idle", {62'd0, if_ack, mem_req}, 64'd0);
    chk("fetch_len", last_req_len, 64'd1);
    repeat (2) @(negedge clk);

    // Simultaneous requests held high
    d_we    = 1'b0;
    d_addr  = 32'h2000;
    if_addr = 32'h3000;
`ifdef ARB_ROUND_ROBIN_EN
    sb.push_back(mk(1'b1, 1'b0, 32'h2000, 32'd0, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 32'h3000, 32'd0, 1'b0));
    sb.push_back(mk(1'b1, 1'b0, 32'h2000, 32'd0, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 32'h3000, 32'd0, 1'b0));
    run(2, 2, 0, "arb");
`else
    for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 1'b0, 32'h2000, 32'd0, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 32'h3000, 32'd0, 1'b0));
    run(4, 1, 0, "arb");
`endif

    // Data write, ready after 3 waits
    d_we    = 1'b1;
    d_addr  = 32'h40;
    d_wdata = 32'hDEADBEEF;
    sb.push_back(mk(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0));
    run(1, 0, 3, "write");
    chk("write_len", last_req_len, 64'd4);
    d_we = 1'b0;

    // Fetch that never completes: times out
    if_addr = 32'h500;
    sb.push_back(mk(1'b0, 1'b0, 32'h500, 32'd0, 1'b1));
    run(0, 1, NEVER, "timeout");
    chk("timeout_len", last_req_len, 64'd5);

    // Ready in the cycle the counter sits at TIMEOUT: success
    d_addr = 32'h600;
    sb.push_back(mk(1'b1, 1'b0, 32'h600, 32'd0, 1'b0));
    run(1, 0, TO, "edge_ok");
    chk("edge_ok_len", last_req_len, 64'd5);

    // Ready one cycle too late: data read times out
    d_addr = 32'h680;
    sb.push_back(mk(1'b1, 1'b0, 32'h680, 32'd0, 1'b1));
    run(1, 0, TO + 1, "edge_to");
    chk("edge_to_len", last_req_len, 64'd5);

    // Reset while BUSY abandons the access; the held request is re-granted
    if_addr   = 32'h700;
    mem_waits = NEVER;
    sb.push_back(mk(1'b0, 1'b0, 32'h700, 32'd0, 1'b0));
    if_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy", {63'd0, mem_req}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b1;
    run(0, 1, 1, "regrant");
    chk("regrant_len", last_req_len, 64'd2);

    chk("sb_empty", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles a granted access waits for mem_ready (1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch read request, level.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata  output  32  fetch data, valid while if_ack=1.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data-access request, level.
REQ-009 d_we  input  1  1=write, 0=read.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  write data.
REQ-012 d_rdata  output  32  read data, valid while d_ack=1; 0 on write acks.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 err  output  1  high with the ack pulse of a timed-out access.
REQ-015 mem_req  output  1  request to the single shared memory port.
REQ-016 mem_we  output  1  memory write enable; always 0 for fetch grants.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-020 mem_ready  input  1  memory completes the current access in this cycle.

Function
REQ-021 FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-022 IDLE: requests sampled each edge; if any pending, latch winner's addr/we/wdata, set mem_req=1, go BUSY.
REQ-023 Priority: d_req beats if_req when both high in the same IDLE cycle (see REQ-035).
REQ-024 BUSY: mem_req, mem_we, mem_addr, mem_wdata held stable; requester inputs ignored.
REQ-025 BUSY and mem_ready=1: capture mem_rdata for reads, drop mem_req, go RESP; wait counter cleared.
REQ-026 BUSY and mem_ready=0: wait counter +1; when counter reaches TIMEOUT, drop mem_req, go RESP with err=1, rdata=0.
REQ-027 mem_ready=1 in the same cycle the counter reaches TIMEOUT: success wins, err=0.
REQ-028 RESP: exactly one of if_ack/d_ack high for one cycle with rdata and err; requests ignored; next state IDLE.
REQ-029 Latency with zero-wait memory: req high before edge 0 -> mem_req after edge 0 -> ack after edge 1 -> IDLE after edge 2.
REQ-030 Requester keeping req high in the IDLE cycle after its ack starts a new access; requesters drop req on the edge that samples ack.
REQ-031 if_rdata/d_rdata/err return to 0 whenever the corresponding ack is 0.

Reset
REQ-032 rst=0 at an edge: state IDLE, all outputs 0, wait counter 0, last-grant register = fetch.
REQ-033 Reset in BUSY or RESP abandons the access: mem_req low next cycle, no ack emitted.
REQ-034 Requests held through reset are first sampled at the first edge with rst=1.

Configuration
REQ-035 ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant goes to the port not granted last (last-grant updated on every grant); undefined: data always wins, fetch may starve, last-grant register absent.

Verification
REQ-036 Fetch only, if_addr=0x100, mem_ready=1 immediately, mem_rdata=0x1234ABCD -> mem_req 1 cycle with addr 0x100, we=0; if_ack 1 cycle later with if_rdata=0x1234ABCD, err=0.
REQ-037 Data write d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready after 3 waits -> mem_we=1, inputs stable 4 cycles, d_ack once, d_rdata=0.
REQ-038 if_req and d_req held high 4 transactions -> macro undefined: D,D,D,D; macro defined: D,F,D,F.
REQ-039 mem_ready never asserted, TIMEOUT=4 -> mem_req high exactly 5 cycles (IDLE grant + 4), ack with err=1, rdata=0; mem_ready on 4th wait cycle -> err=0.
REQ-040 rst=0 for one edge while BUSY -> no ack, all outputs 0 next cycle, pending request re-granted after reset release.
